// File: rtl/input_debounce_pkg.sv
`default_nettype none
// ============================================================================
// Module      : step_input_pkg
// Description : Shared constants and helpers for the STEP input debouncer.
// Revision    : 1.0 - initial release
// ============================================================================
package step_input_pkg;

  // Default number of consecutive stable samples needed to accept a change.
  localparam int DEBOUNCE_DEFAULT = 4;

  // Width of a counter that must hold values 0 .. n-1; never narrower than 1.
  function automatic int cnt_width(input int n);
    int w;
    w = $clog2(n);
    if (w < 1) begin
      w = 1;
    end
    return w;
  endfunction

endpackage : step_input_pkg
`default_nettype wire

// File: rtl/input_debounce_if.sv
`default_nettype none
// ============================================================================
// Module      : input_debounce_if
// Description : Pin-side input and debounced outputs of one input group.
//               The falling-edge event is called release_pulse because
//               "release" is a reserved word in SystemVerilog.
// Revision    : 1.0 - initial release
// ============================================================================
interface input_debounce_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] raw_in;
  logic [WIDTH-1:0] level;
  logic [WIDTH-1:0] press;
  logic [WIDTH-1:0] release_pulse;
  logic             any_press;

  // Board/stimulus side: drives the pins, observes the conditioned state.
  modport master (
    output raw_in,
    input  level,
    input  press,
    input  release_pulse,
    input  any_press
  );

  // Debouncer side: consumes the pins, produces the conditioned state.
  modport slave (
    input  raw_in,
    output level,
    output press,
    output release_pulse,
    output any_press
  );
endinterface : input_debounce_if
`default_nettype wire

// File: rtl/input_debounce_chan.sv
`default_nettype none
// ============================================================================
// Module      : debounce_chan
// Description : One debounce channel: 2-flop synchronizer, polarity
//               normalisation, stability counter, accepted level and
//               single-cycle press/release pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module debounce_chan
  import step_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic raw_in,
  output logic      level,
  output logic      press,
  output logic      release_pulse
);

  localparam int                 c_CNT_W   = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

  logic               r_sync1;
  logic               r_sync2;
  logic               w_s;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_level;
  logic               r_press;
  logic               r_release;

  // Bring the asynchronous pin into the clock domain; reset to the idle pin value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= ACTIVE_LOW;
      r_sync2 <= ACTIVE_LOW;
    end else begin
      r_sync1 <= raw_in;
      r_sync2 <= r_sync1;
    end
  end

  // After normalisation, 1 always means pressed/on regardless of pin polarity.
  assign w_s = r_sync2 ^ ACTIVE_LOW;

  // Accept a new level only after DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_press   <= 1'b0;
      r_release <= 1'b0;
      if (w_s == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == c_CNT_MAX) begin
        r_level   <= w_s;
        r_cnt     <= '0;
        r_press   <= w_s;
        r_release <= ~w_s;
      end else begin
        r_cnt <= r_cnt + c_CNT_ONE;
      end
    end
  end

  assign level         = r_level;
  assign press         = r_press;
  assign release_pulse = r_release;

endmodule : debounce_chan
`default_nettype wire

// File: rtl/input_debounce.sv
`default_nettype none
// ============================================================================
// Module      : input_debounce
// Description : Debounces a group of WIDTH independent active-low (or
//               active-high) board inputs into clean levels and one-cycle
//               press/release events, plus a group-wide press indicator.
// Revision    : 1.0 - initial release
// ============================================================================
module input_debounce
  import step_input_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input wire logic        clk,
  input wire logic        rst,
  input_debounce_if.slave bus
);

  logic [WIDTH-1:0] w_level;
  logic [WIDTH-1:0] w_press;
  logic [WIDTH-1:0] w_release;

  // A one-sample filter cannot reject anything; refuse to build it.
  if (DEBOUNCE_CYCLES < 2) begin : g_param_check
    $error("input_debounce: DEBOUNCE_CYCLES must be >= 2");
  end

  // One fully independent filter per input channel.
  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    debounce_chan #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .ACTIVE_LOW      (ACTIVE_LOW)
    ) u_chan (
      .clk           (clk),
      .rst           (rst),
      .raw_in        (bus.raw_in[i]),
      .level         (w_level[i]),
      .press         (w_press[i]),
      .release_pulse (w_release[i])
    );
  end

  assign bus.level         = w_level;
  assign bus.press         = w_press;
  assign bus.release_pulse = w_release;
  // press bits are already registered, so the OR lines up with them without a flop.
  assign bus.any_press     = |w_press;

endmodule : input_debounce
`default_nettype wire

// File: tb/tb_input_debounce.sv
`default_nettype none
// ============================================================================
// Module      : tb_input_debounce
// Description : Self-checking bench for input_debounce. A reference model
//               keeps a short history of sampled pins per channel and flips
//               a channel's level once the synchronised samples have
//               disagreed with it for DEBOUNCE_CYCLES edges in a row.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_input_debounce;

  localparam int W  = 4;
  localparam int D  = 4;
  localparam bit AL = 1'b1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  input_debounce_if #(.WIDTH(W)) bus ();

  input_debounce #(
    .WIDTH           (W),
    .DEBOUNCE_CYCLES (D),
    .ACTIVE_LOW      (AL)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Single comparison point: counts and reports mismatches.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // hist[0] is the pin value sampled at the latest edge, hist[k] k edges earlier.
  logic [W-1:0] hist [D+2];
  logic [W-1:0] m_level;
  logic [W-1:0] m_press;
  logic [W-1:0] m_rel;

  task automatic model_reset();
    for (int k = 0; k < D + 2; k++) hist[k] = {W{AL}};
    m_level = '0;
    m_press = '0;
    m_rel   = '0;
  endtask

  task automatic model_edge(input logic [W-1:0] r);
    logic differs;
    for (int k = D + 1; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = r;
    m_press = '0;
    m_rel   = '0;
    for (int ch = 0; ch < W; ch++) begin
      // The filter at this edge sees the pin two edges late; look at the last D such samples.
      differs = 1'b1;
      for (int k = 2; k <= D + 1; k++) begin
        if ((hist[k][ch] ^ AL) == m_level[ch]) differs = 1'b0;
      end
      if (differs) begin
        m_level[ch] = ~m_level[ch];
        if (m_level[ch]) m_press[ch] = 1'b1;
        else             m_rel[ch]   = 1'b1;
      end
    end
  endtask

  task automatic check_outputs();
    check("level",     32'(bus.level),         32'(m_level));
    check("press",     32'(bus.press),         32'(m_press));
    check("release",   32'(bus.release_pulse), 32'(m_rel));
    check("any_press", 32'(bus.any_press),     32'(|m_press));
  endtask

  // Drive pins at the negative edge, advance one rising edge, compare 1 ns later.
  task automatic step(input logic [W-1:0] r);
    bus.raw_in = r;
    @(posedge clk);
    if (!rst) model_edge(r);
    #1;
    check_outputs();
    @(negedge clk);
  endtask

  logic [W-1:0] pins;
  int           hold [W];
  int           pulses;

  initial begin
    bus.raw_in = '1;
    rst        = 1'b1;
    model_reset();
    @(negedge clk);
    step(4'b1111);
    rst = 1'b0;

    // Clean press and release on channel 0.
    repeat (3) step(4'b1111);
    for (int i = 0; i < 8; i++) begin
      step(4'b1110);
      if (i == 4) check("press0_not_before_edge5", 32'(bus.press), 32'(0));
      if (i == 5) check("press0_at_edge5", 32'(bus.press), 32'(4'b0001));
      if (i == 6) check("press0_one_cycle", 32'(bus.any_press), 32'(0));
    end
    for (int i = 0; i < 8; i++) begin
      step(4'b1111);
      if (i == 5) check("release0_at_edge5", 32'(bus.release_pulse), 32'(4'b0001));
    end

    // Glitch of 3 cycles on channel 1 is rejected; 4 cycles is accepted.
    pulses = 0;
    repeat (3) step(4'b1101);
    repeat (20) begin
      step(4'b1111);
      pulses += int'(bus.press[1] | bus.release_pulse[1] | bus.level[1]);
    end
    check("glitch3_rejected", 32'(pulses), 32'(0));
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      step(4'b1101);
      pulses += int'(bus.press[1]);
    end
    repeat (12) begin
      step(4'b1111);
      pulses += int'(bus.press[1]);
    end
    check("glitch4_accepted", 32'(pulses), 32'(1));

    // Channels 2 and 3 pressed together.
    for (int i = 0; i < 8; i++) begin
      step(4'b0011);
      if (i == 5) check("simul_press", 32'(bus.press), 32'(4'b1100));
    end
    repeat (8) step(4'b1111);

    // Asynchronous reset mid-cycle clears everything at once.
    repeat (8) step(4'b1110);
    bus.raw_in = 4'b1111;
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check("async_rst_level", 32'(bus.level), 32'(0));
    check("async_rst_any",   32'(bus.any_press), 32'(0));
    @(negedge clk);
    repeat (2) step(4'b1111);
    rst = 1'b0;
    repeat (20) step(4'b1111);

    // Pin held pressed through reset deassertion.
    rst = 1'b1;
    model_reset();
    repeat (3) step(4'b1110);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(4'b1110);
      if (i == 5) check("pressed_thru_rst", 32'(bus.press), 32'(4'b0001));
    end
    repeat (8) step(4'b1111);

    // Reset while the counter is part-way: progress is discarded.
    repeat (4) step(4'b1110);
    rst = 1'b1;
    model_reset();
    repeat (2) step(4'b1110);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(4'b1110);
      if (i == 4) check("midcount_no_early", 32'(bus.level), 32'(0));
      if (i == 5) check("midcount_accept", 32'(bus.press), 32'(4'b0001));
    end

    // Randomised holds and glitches on all channels, with occasional resets.
    pins = 4'b1110;
    for (int ch = 0; ch < W; ch++) hold[ch] = 0;
    for (int c = 0; c < 1500; c++) begin
      for (int ch = 0; ch < W; ch++) begin
        if (hold[ch] == 0) begin
          pins[ch] = ~pins[ch];
          hold[ch] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, D - 1)) - 1
                                                 : int'($urandom_range(D, 3 * D)) - 1;
        end else begin
          hold[ch]--;
        end
      end
      if (rst) begin
        rst = 1'b0;
      end else if ($urandom_range(0, 249) == 0) begin
        rst = 1'b1;
        model_reset();
      end
      step(pins);
    end
    rst = 1'b0;
    repeat (12) step(4'b1111);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_input_debounce
`default_nettype wire
